vga_pixel_fetch: RTL and testbench

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pkg.sv | 18 +
 rtl/pixel_fifo.sv | 70 +++++++
 rtl/vga_pixel_fetch.sv | 174 +++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pipeline (timing stage and pixel fetch).
// Holds the default frame geometry, pixel/address widths and the
// pixel-fetch FSM state encoding.
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int PIX_W        = 12;
    localparam int ADDR_W       = 19;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        RUN
    } fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock synchronous pixel prefetch FIFO with first-word fall-through
// read data and an occupancy count.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   clr          - synchronous empty (pointers and count to zero)
//   push/wr_data - write one entry (ignored when full)
//   pop          - discard the head entry (ignored when empty)
//   rd_data      - current head entry, valid whenever empty=0
//   count        - number of stored entries (0..DEPTH)
//   empty        - count == 0
module pixel_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage: issues sequential frame-buffer reads ahead of the
// display, buffers returned pixels in a prefetch FIFO and emits them aligned
// to the timing stage's sync/DE with a fixed one-cycle latency.
// Ports:
//   clk, rst_n                    - pixel clock, synchronous active-low reset
//   h_sync_in, v_sync_in, de_in   - timing from the timing stage
//   rd_req, rd_addr, rd_gnt       - read request / address / accept
//   rd_valid, rd_data             - in-order read return
//   h_sync_out, v_sync_out,
//   de_out, rgb_out               - aligned video out (rgb_out=0 outside DE)
//   underrun                      - sticky, set when a DE pixel had no data,
//                                   cleared when a new frame starts running
module vga_pixel_fetch #(
    parameter int                H_ACTIVE     = vga_pkg::H_ACTIVE,
    parameter int                V_ACTIVE     = vga_pkg::V_ACTIVE,
    parameter int                PIX_W        = vga_pkg::PIX_W,
    parameter int                ADDR_W       = vga_pkg::ADDR_W,
    parameter int                FIFO_DEPTH   = 16,
    parameter logic              VS_POL       = 1'b0,
    parameter logic [PIX_W-1:0]  UNDERRUN_PIX = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              de_in,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              de_out,
    output logic [PIX_W-1:0]  rgb_out,
    output logic              underrun
);

    import vga_pkg::*;

    localparam int unsigned       FRAME_PIX    = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_PIX - 1);
    localparam int                CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]    CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_next;

    logic             vs_d;
    logic             frame_start;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [PIX_W-1:0] fifo_head;
    logic [CNT_W:0]   credit_sum;

    logic             grant;
    logic             push;
    logic             pop;
    logic             starve;
    logic             run_start;

    // Frame start: v_sync_in has just moved to its active level.
    assign frame_start = (v_sync_in == VS_POL) && (vs_d != VS_POL);

    // Every granted read will land in the FIFO, so the words in flight
    // reserve FIFO space; this is what makes a push into a full FIFO impossible.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (run_start),
        .push    (push),
        .wr_data (rd_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. FLUSH waits for every in-flight read to return so
    // that stale data from the previous frame never reaches the FIFO.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = FLUSH;
            FLUSH:   if (!frame_start && (outstanding == '0)) state_next = RUN;
            RUN:     if (frame_start) state_next = FLUSH;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs / datapath controls
    always_comb begin
        rd_req    = 1'b0;
        grant     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        starve    = 1'b0;
        run_start = 1'b0;
        if (state == RUN) begin
            rd_req = (credit_sum < CREDIT_LIMIT);
            push   = rd_valid;
            pop    = de_in && !fifo_empty;
        end
        grant     = rd_req && rd_gnt;
        starve    = de_in && !pop;
        run_start = (state == FLUSH) && (state_next == RUN);
    end

    // Read address and in-flight counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr     <= '0;
            outstanding <= '0;
            vs_d        <= ~VS_POL;
        end else begin
            vs_d <= v_sync_in;
            if (run_start) begin
                rd_addr <= '0;
            end else if (grant) begin
                rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
            end
            case ({grant, rd_valid})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Aligned video outputs and sticky underrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            de_out     <= 1'b0;
            rgb_out    <= '0;
            underrun   <= 1'b0;
        end else begin
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
            de_out     <= de_in;
            if (pop) begin
                rgb_out <= fifo_head;
            end else if (de_in) begin
                rgb_out <= UNDERRUN_PIX;
            end else begin
                rgb_out <= '0;
            end
            // Clearing on entry to RUN takes priority over a starved pixel
            // in that same cycle.
            if (run_start) begin
                underrun <= 1'b0;
            end else if (starve) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed, self-checking bench for vga_pixel_fetch. A small frame
// (16x4 = 64 pixels) keeps the address wrap reachable in a short run.
// The memory model returns data = addr + 1 + salt after a programmable latency.
module tb_vga_pixel_fetch;

    localparam int HA    = 16;
    localparam int VA    = 4;
    localparam int FP    = HA * VA;
    localparam int PW    = 12;
    localparam int AW    = 19;
    localparam int DEPTH = 16;
    localparam logic [PW-1:0] UPIX = 12'hF0F;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          h_sync_in = 1'b0;
    logic          v_sync_in = 1'b1;
    logic          de_in     = 1'b0;
    logic          rd_gnt    = 1'b0;
    logic          rd_valid  = 1'b0;
    logic [PW-1:0] rd_data   = '0;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          h_sync_out;
    logic          v_sync_out;
    logic          de_out;
    logic [PW-1:0] rgb_out;
    logic          underrun;

    vga_pixel_fetch #(
        .H_ACTIVE     (HA),
        .V_ACTIVE     (VA),
        .PIX_W        (PW),
        .ADDR_W       (AW),
        .FIFO_DEPTH   (DEPTH),
        .VS_POL       (1'b0),
        .UNDERRUN_PIX (UPIX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .de_in      (de_in),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .de_out     (de_out),
        .rgb_out    (rgb_out),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        logic [PW-1:0] data;
    } rd_t;

    typedef struct {
        logic          vs;
        logic          hs;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
    } vec_t;

    rd_t           q[$];
    int unsigned   cyc     = 0;
    int unsigned   lat     = 3;
    int unsigned   granted = 0;
    int unsigned   pops    = 0;
    int unsigned   wraps   = 0;
    logic [PW-1:0] salt    = '0;
    int            n_cmp   = 0;
    int            n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_req"}, 32'(rd_req), 0);
        chk({name, "_rd_addr"}, 32'(rd_addr), 0);
        chk({name, "_hs_out"}, 32'(h_sync_out), 0);
        chk({name, "_vs_out"}, 32'(v_sync_out), 0);
        chk({name, "_de_out"}, 32'(de_out), 0);
        chk({name, "_rgb"}, 32'(rgb_out), 0);
        chk({name, "_underrun"}, 32'(underrun), 0);
    endtask

    // One clock: samples the grant before the edge, then updates the memory
    // model and checks the address step for every accepted request.
    task automatic tick();
        logic          g;
        logic [AW-1:0] a;
        int unsigned   exp_a;
        rd_t           e;
        g = rst_n && rd_req && rd_gnt;
        a = rd_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            q.delete();
            rd_valid = 1'b0;
            rd_data  = '0;
        end else begin
            if (g) begin
                e.due  = cyc + lat;
                e.data = PW'(int'(a) + 1 + int'(salt));
                q.push_back(e);
                granted++;
                exp_a = (int'(a) == FP - 1) ? 0 : int'(a) + 1;
                if (int'(a) == FP - 1) wraps++;
                chk("addr_step", 32'(rd_addr), 32'(exp_a));
            end
            if (q.size() > 0 && q[0].due <= cyc + 1) begin
                rd_valid = 1'b1;
                rd_data  = q[0].data;
                void'(q.pop_front());
            end else begin
                rd_valid = 1'b0;
                rd_data  = '0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[22];
        logic under;
        logic [PW-1:0] exp_px;

        vt[0] = '{vs: 1'b1, hs: 1'b0, exp_req: 1'b0, exp_addr: '0};
        vt[1] = '{vs: 1'b0, hs: 1'b1, exp_req: 1'b0, exp_addr: '0};
        vt[2] = '{vs: 1'b0, hs: 1'b0, exp_req: 1'b1, exp_addr: '0};
        for (int i = 3; i < 22; i++) begin
            vt[i].vs       = 1'b1;
            vt[i].hs       = (i % 2 == 1);
            vt[i].exp_req  = ((i - 2) < DEPTH);
            vt[i].exp_addr = AW'(((i - 2) < DEPTH) ? (i - 2) : DEPTH);
        end

        // Reset with sync inputs at non-zero levels
        rst_n = 1'b0; v_sync_in = 1'b1; rd_gnt = 1'b1; lat = 3;
        tick(); tick();
        chk_zero("reset");
        rst_n = 1'b1;

        // First frame start: one FLUSH cycle, then sequential fetch to credit limit
        for (int i = 0; i < 22; i++) begin
            v_sync_in = vt[i].vs;
            h_sync_in = vt[i].hs;
            tick();
            chk("tbl_rd_req", 32'(rd_req), 32'(vt[i].exp_req));
            chk("tbl_rd_addr", 32'(rd_addr), 32'(vt[i].exp_addr));
            chk("tbl_hs_out", 32'(h_sync_out), 32'(vt[i].hs));
            chk("tbl_vs_out", 32'(v_sync_out), 32'(vt[i].vs));
            chk("tbl_de_out", 32'(de_out), 0);
            chk("tbl_rgb", 32'(rgb_out), 0);
            chk("tbl_underrun", 32'(underrun), 0);
        end
        chk("credit_granted", granted, DEPTH);
        tick(); tick(); tick();

        // Active video with memory keeping pace; address wraps mid-way
        for (int k = 0; k < 80; k++) begin
            de_in = 1'b1;
            h_sync_in = (k % 2 == 1);
            tick();
            chk("run_de_out", 32'(de_out), 1);
            chk("run_hs_out", 32'(h_sync_out), 32'(k % 2 == 1));
            chk("run_rgb", 32'(rgb_out), 32'(PW'((pops % FP) + 1)));
            pops++;
            chk("run_underrun", 32'(underrun), 0);
        end
        de_in = 1'b0; h_sync_in = 1'b0;
        tick();
        chk("blank_de_out", 32'(de_out), 0);
        chk("blank_rgb", 32'(rgb_out), 0);
        chk("addr_wrapped_once", wraps, 1);

        // Grants withheld: FIFO drains, then underrun colour and sticky flag
        rd_gnt = 1'b0; under = 1'b0;
        for (int k = 0; k < 30; k++) begin
            de_in = 1'b1;
            tick();
            if (granted > pops) begin
                exp_px = PW'((pops % FP) + 1);
                pops++;
            end else begin
                exp_px = UPIX;
                under = 1'b1;
            end
            chk("drain_rgb", 32'(rgb_out), 32'(exp_px));
            chk("drain_underrun", 32'(underrun), 32'(under));
        end
        chk("drain_reached_underrun", 32'(under), 1);
        de_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_underrun", 32'(underrun), 1);
            chk("hold_rgb", 32'(rgb_out), 0);
        end
        v_sync_in = 1'b0;
        tick();
        chk("fs_flush_underrun", 32'(underrun), 1);
        chk("fs_flush_rd_req", 32'(rd_req), 0);
        tick();
        chk("fs_run_underrun", 32'(underrun), 0);
        chk("fs_run_rd_addr", 32'(rd_addr), 0);
        chk("fs_run_rd_req", 32'(rd_req), 1);

        // Frame start with 5 reads in flight: stale words must be discarded
        v_sync_in = 1'b1; salt = 12'h100; lat = 10; rd_gnt = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("inflight_addr", 32'(rd_addr), 5);
        rd_gnt = 1'b0; v_sync_in = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            rd_gnt = 1'b1;
            chk("flush_rd_req", 32'(rd_req), 32'(k == 11));
            chk("flush_rd_addr", 32'(rd_addr), (k == 11) ? 0 : 5);
        end
        v_sync_in = 1'b1; salt = '0; lat = 1;
        for (int k = 0; k < 20; k++) tick();
        chk("refill_addr", 32'(rd_addr), DEPTH);
        chk("refill_rd_req", 32'(rd_req), 0);
        de_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("postflush_rgb", 32'(rgb_out), 32'(PW'(k + 1)));
            chk("postflush_underrun", 32'(underrun), 0);
        end

        // Reset asserted mid-line with reads in flight
        lat = 4;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("preline_rgb", 32'(rgb_out), 32'(PW'(k + 6)));
        end
        rst_n = 1'b0; h_sync_in = 1'b1;
        tick();
        chk_zero("midline_reset");
        rst_n = 1'b1; h_sync_in = 1'b0; de_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("idle_rd_req", 32'(rd_req), 0);
            chk("idle_rd_addr", 32'(rd_addr), 0);
        end
        de_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("idle_de_out", 32'(de_out), 1);
            chk("idle_rgb", 32'(rgb_out), 32'(UPIX));
            chk("idle_underrun", 32'(underrun), 1);
        end
        de_in = 1'b0; v_sync_in = 1'b0;
        tick();
        tick();
        chk("rst_run_rd_req", 32'(rd_req), 1);
        chk("rst_run_rd_addr", 32'(rd_addr), 0);
        chk("rst_run_underrun", 32'(underrun), 0);
        v_sync_in = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("rst_refill_addr", 32'(rd_addr), DEPTH);
        de_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_rgb", 32'(rgb_out), 32'(PW'(k + 1)));
        end
        de_in = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
